// File: rtl/image_xfer_pkg.sv
// Shared Pi <-> FPGA handshake encodings for the image receiver.
// Also holds the checkerboard rule used for the power-on test frame.
package image_xfer_pkg;

    typedef enum logic [1:0] {
        PI_BUSY     = 2'b00,
        PI_READY    = 2'b01,
        PI_CONTINUE = 2'b11,
        PI_DONE     = 2'b10
    } pi_state_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b11,
        ST_READING    = 2'b10,
        ST_BLOCK_DONE = 2'b01,
        ST_FRAME_DONE = 2'b00
    } fpga_state_e;

    // Bright pixel where row and column parity match (top-left corner is bright).
    function automatic logic checkerBright(input int row, input int col);
        return ((row + col) % 2) == 0;
    endfunction

endpackage

// File: rtl/image_pingpong_buf.sv
// Two frame banks: beats are written into the back bank, the front bank drives the image.
// A swap flips the roles; reset selects bank 0 as front and fills it with the test frame.
module image_pingpong_buf
    import image_xfer_pkg::*;
#(
    parameter int PIX_W        = 8,
    parameter int IMG_W        = 28,
    parameter int IMG_H        = 28,
    parameter int LANES        = 4,
    parameter int TEST_PATTERN = 1,
    localparam int NPIX        = IMG_W * IMG_H,
    localparam int NBEATS      = NPIX / LANES,
    localparam int ADDR_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1,
    localparam int PIX_IDX_W   = (NPIX > 1) ? $clog2(NPIX) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_we,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [LANES*PIX_W-1:0]  i_data,
    input  logic                    i_swap,
    output logic [NPIX*PIX_W-1:0]   o_image
);

    logic [PIX_W-1:0] r_bank [2][NPIX];
    logic             r_sel;
    logic             w_backSel;

    assign w_backSel = ~r_sel;

    // The back bank is deliberately left alone on reset; it is overwritten by the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel <= 1'b0;
            for (int row = 0; row < IMG_H; row++) begin
                for (int col = 0; col < IMG_W; col++) begin
                    r_bank[0][PIX_IDX_W'(row * IMG_W + col)] <=
                        (TEST_PATTERN != 0 && checkerBright(row, col)) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
                end
            end
        end else begin
            if (i_swap) begin
                r_sel <= ~r_sel;
            end
            if (i_we) begin
                for (int l = 0; l < LANES; l++) begin
                    r_bank[w_backSel][PIX_IDX_W'(int'(i_addr) * LANES + l)] <= i_data[l*PIX_W +: PIX_W];
                end
            end
        end
    end

    for (genvar p = 0; p < NPIX; p++) begin : g_front
        assign o_image[p*PIX_W +: PIX_W] = r_sel ? r_bank[1][p] : r_bank[0][p];
    end

endmodule

// File: rtl/image_rx_pingpong.sv
// Pi -> FPGA image receiver: block-wise handshake FSM plus beat/block counters,
// feeding a ping-pong frame buffer so the classifier always sees a complete frame.
module image_rx_pingpong
    import image_xfer_pkg::*;
#(
    parameter int PIX_W        = 8,
    parameter int IMG_W        = 28,
    parameter int IMG_H        = 28,
    parameter int LANES        = 4,
    parameter int BLOCK_BEATS  = 7,
    parameter int TEST_PATTERN = 1,
    localparam int NPIX        = IMG_W * IMG_H,
    localparam int NBEATS      = NPIX / LANES,
    localparam int PIX_CNT_W   = $clog2(NPIX + 1),
    localparam int BEAT_W      = $clog2(NBEATS + 1),
    localparam int BLK_W       = $clog2(BLOCK_BEATS + 1),
    localparam int ADDR_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_en,
    input  logic [1:0]              pi_state,
    input  logic [LANES*PIX_W-1:0]  pi_data,
    output logic [1:0]              fpga_state,
    output logic [NPIX*PIX_W-1:0]   image,
    output logic                    frame_valid,
    output logic                    frame_done,
    output logic [PIX_CNT_W-1:0]    pix_count,
    output logic                    err
);

    fpga_state_e       r_state, w_nextState;
    logic [BEAT_W-1:0] r_beatCnt;
    logic [BLK_W-1:0]  r_blkCnt;
    logic              r_frameValid, r_err;
    logic              w_beat, w_swap, w_setErr, w_clrBeats, w_frameFull, w_lastOfBlock;

    assign w_frameFull   = (r_beatCnt == BEAT_W'(NBEATS));
    assign w_lastOfBlock = (r_blkCnt == BLK_W'(BLOCK_BEATS - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_nextState;
    end

    // Any DONE/CONTINUE that disagrees with the beat count throws the partial frame away.
    always_comb begin
        w_nextState = r_state;
        w_beat      = 1'b0;
        w_swap      = 1'b0;
        w_setErr    = 1'b0;
        w_clrBeats  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (rd_en && pi_state == PI_READY) w_nextState = ST_READING;
            end
            ST_READING: begin
                if (rd_en) begin
                    w_beat = 1'b1;
                    if (w_lastOfBlock) w_nextState = ST_BLOCK_DONE;
                end
            end
            ST_BLOCK_DONE: begin
                if (rd_en && pi_state == PI_CONTINUE) begin
                    w_nextState = ST_IDLE;
                    if (w_frameFull) begin
                        w_setErr   = 1'b1;
                        w_clrBeats = 1'b1;
                    end
                end else if (rd_en && pi_state == PI_DONE) begin
                    w_clrBeats = 1'b1;
                    if (w_frameFull) begin
                        w_swap      = 1'b1;
                        w_nextState = ST_FRAME_DONE;
                    end else begin
                        w_setErr    = 1'b1;
                        w_nextState = ST_IDLE;
                    end
                end
            end
            ST_FRAME_DONE: w_nextState = ST_IDLE;
            default:       w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beatCnt    <= '0;
            r_blkCnt     <= '0;
            r_frameValid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_beat) begin
                r_beatCnt <= r_beatCnt + 1'b1;
                r_blkCnt  <= w_lastOfBlock ? '0 : r_blkCnt + 1'b1;
            end
            if (w_clrBeats) r_beatCnt <= '0;
            if (w_setErr)   r_err <= 1'b1;
            if (w_swap)     r_frameValid <= 1'b1;
        end
    end

    image_pingpong_buf #(
        .PIX_W        (PIX_W),
        .IMG_W        (IMG_W),
        .IMG_H        (IMG_H),
        .LANES        (LANES),
        .TEST_PATTERN (TEST_PATTERN)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_beat),
        .i_addr  (ADDR_W'(r_beatCnt)),
        .i_data  (pi_data),
        .i_swap  (w_swap),
        .o_image (image)
    );

    assign fpga_state  = r_state;
    assign frame_done  = (r_state == ST_FRAME_DONE);
    assign frame_valid = r_frameValid;
    assign err         = r_err;
    assign pix_count   = PIX_CNT_W'(r_beatCnt) * PIX_CNT_W'(LANES);

endmodule

// File: tb/tb_image_rx_pingpong.sv
// Directed bench for image_rx_pingpong at default parameters (28x28, 4 lanes, 7-beat blocks).
// Frames, aborts, stalls and mid-frame reset against hand-computed expectations.
module tb_image_rx_pingpong;

    localparam int NPIX = 784;

    localparam logic [1:0] BUSY     = 2'b00;
    localparam logic [1:0] READY    = 2'b01;
    localparam logic [1:0] CONTINUE = 2'b11;
    localparam logic [1:0] DONE     = 2'b10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 rd_en;
    logic [1:0]           pi_state;
    logic [31:0]          pi_data;
    logic [1:0]           fpga_state;
    logic [NPIX*8-1:0]    image;
    logic                 frame_valid;
    logic                 frame_done;
    logic [9:0]           pix_count;
    logic                 err;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    image_rx_pingpong dut (
        .clk         (clk),
        .reset       (reset),
        .rd_en       (rd_en),
        .pi_state    (pi_state),
        .pi_data     (pi_data),
        .fpga_state  (fpga_state),
        .image       (image),
        .frame_valid (frame_valid),
        .frame_done  (frame_done),
        .pix_count   (pix_count),
        .err         (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed === expected) nPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    function automatic logic [7:0] pixVal(input int p, input bit inv);
        logic [7:0] v;
        v = 8'(p % 256);
        return inv ? ~v : v;
    endfunction

    function automatic logic [7:0] imgPix(input int p);
        return image[p*8 +: 8];
    endfunction

    function automatic int imageErrors(input bit inv);
        int n = 0;
        for (int p = 0; p < NPIX; p++) if (imgPix(p) !== pixVal(p, inv)) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] ps, input logic [31:0] data);
        rd_en    = en;
        pi_state = ps;
        pi_data  = data;
        step();
    endtask

    task automatic sendBeats(input int firstBeat, input int n, input bit inv);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < 4; l++) d[l*8 +: 8] = pixVal((firstBeat + i) * 4 + l, inv);
            applyStimulus(1'b1, BUSY, d);
        end
    endtask

    // Leaves the DUT in BLOCK_DONE after the last block; caller issues the final handshake.
    task automatic sendBlocks(input int nBlocks, input bit inv);
        for (int b = 0; b < nBlocks; b++) begin
            applyStimulus(1'b1, READY, 32'h0);
            sendBeats(b * 7, 7, inv);
            if (b < nBlocks - 1) applyStimulus(1'b1, CONTINUE, 32'h0);
        end
    endtask

    task automatic checkCheckerboard(input string tag);
        checkOutput({tag, "_pix0"},  32'(imgPix(0)),  32'hFF);
        checkOutput({tag, "_pix1"},  32'(imgPix(1)),  32'h00);
        checkOutput({tag, "_pix28"}, 32'(imgPix(28)), 32'h00);
        checkOutput({tag, "_pix29"}, 32'(imgPix(29)), 32'hFF);
    endtask

    initial begin
        reset = 1'b1; rd_en = 1'b0; pi_state = BUSY; pi_data = 32'h0;
        step();
        step();
        reset = 1'b0;

        checkOutput("rst_state", 32'(fpga_state), 32'h3);
        checkOutput("rst_valid", 32'(frame_valid), 32'h0);
        checkOutput("rst_done",  32'(frame_done), 32'h0);
        checkOutput("rst_err",   32'(err), 32'h0);
        checkOutput("rst_count", 32'(pix_count), 32'd0);
        checkCheckerboard("rst");

        applyStimulus(1'b1, BUSY, 32'h0);
        checkOutput("idle_busy", 32'(fpga_state), 32'h3);
        applyStimulus(1'b0, READY, 32'h0);
        checkOutput("idle_noen", 32'(fpga_state), 32'h3);

        sendBlocks(28, 1'b0);
        checkOutput("f1_blkdone", 32'(fpga_state), 32'h1);
        checkOutput("f1_count",   32'(pix_count), 32'd784);
        checkOutput("f1_valid0",  32'(frame_valid), 32'h0);
        checkOutput("f1_front",   32'(imgPix(0)), 32'hFF);
        applyStimulus(1'b1, DONE, 32'h0);
        checkOutput("f1_done",    32'(frame_done), 32'h1);
        checkOutput("f1_state",   32'(fpga_state), 32'h0);
        checkOutput("f1_valid",   32'(frame_valid), 32'h1);
        checkOutput("f1_image",   32'(imageErrors(1'b0)), 32'd0);
        checkOutput("f1_pix300",  32'(imgPix(300)), 32'h2C);
        checkOutput("f1_pix783",  32'(imgPix(783)), 32'h0F);
        applyStimulus(1'b0, BUSY, 32'h0);
        checkOutput("f1_done_end", 32'(frame_done), 32'h0);
        checkOutput("f1_idle",     32'(fpga_state), 32'h3);
        checkOutput("f1_count0",   32'(pix_count), 32'd0);
        checkOutput("f1_err",      32'(err), 32'h0);

        sendBlocks(28, 1'b1);
        checkOutput("f2_hold_img", 32'(imageErrors(1'b0)), 32'd0);
        checkOutput("f2_nodone",   32'(frame_done), 32'h0);
        applyStimulus(1'b1, DONE, 32'h0);
        checkOutput("f2_done",     32'(frame_done), 32'h1);
        checkOutput("f2_image",    32'(imageErrors(1'b1)), 32'd0);
        checkOutput("f2_pix5",     32'(imgPix(5)), 32'hFA);
        applyStimulus(1'b0, BUSY, 32'h0);

        sendBlocks(10, 1'b0);
        checkOutput("short_count", 32'(pix_count), 32'd280);
        applyStimulus(1'b1, DONE, 32'h0);
        checkOutput("short_nodone", 32'(frame_done), 32'h0);
        checkOutput("short_err",    32'(err), 32'h1);
        checkOutput("short_state",  32'(fpga_state), 32'h3);
        checkOutput("short_count0", 32'(pix_count), 32'd0);
        checkOutput("short_image",  32'(imageErrors(1'b1)), 32'd0);
        applyStimulus(1'b0, BUSY, 32'h0);
        checkOutput("short_sticky", 32'(err), 32'h1);

        sendBlocks(5, 1'b0);
        applyStimulus(1'b1, CONTINUE, 32'h0);
        applyStimulus(1'b1, READY, 32'h0);
        sendBeats(35, 3, 1'b0);
        checkOutput("stall_count", 32'(pix_count), 32'd152);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, READY, 32'hDEADBEEF);
            checkOutput("stall_hold", 32'(pix_count), 32'd152);
        end
        checkOutput("stall_state", 32'(fpga_state), 32'h2);

        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("mrst_state", 32'(fpga_state), 32'h3);
        checkOutput("mrst_count", 32'(pix_count), 32'd0);
        checkOutput("mrst_valid", 32'(frame_valid), 32'h0);
        checkOutput("mrst_err",   32'(err), 32'h0);
        checkCheckerboard("mrst");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
